// File: rtl/apb_pkg.sv
// Shared APB completer definitions: FSM states, default widths and address error decode.
package apb_pkg;

  localparam int unsigned APB_ADDR_WIDTH = 32;
  localparam int unsigned APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess
  } apb_state_e;

  // Byte address is bad when not word aligned or beyond the last word of a depth-word memory.
  function automatic logic addr_err(input logic [63:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || (addr >= (64'(depth) << 2));
  endfunction

endpackage

// File: rtl/apb_mem_slave_ram.sv
// Single-port word RAM with a registered, resettable read port and a write enable.
module apb_mem_slave_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_en,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic [DATA_WIDTH-1:0]      rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wdata;
    end
  end

  // Read register only updates on a read strobe, so the last result is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/apb_mem_slave.sv
// APB3 completer in front of a word-addressed memory with configurable wait states.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  apb_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic                  setup;
  logic                  xfer;
  logic                  rd_en;
  logic                  wr_en;
  logic [IdxW-1:0]       ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign setup = PSEL & ~PENABLE;
  assign xfer  = PSEL & PENABLE;

  // Next-state, transfer latching and RAM strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    err_d   = err_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      StIdle: begin
        // PENABLE without a preceding setup cycle is ignored here.
        if (setup) begin
          idx_d   = PADDR[IdxW+1:2];
          write_d = PWRITE;
          err_d   = addr_err(64'(PADDR), DEPTH);
          cnt_d   = 4'(WAIT_STATES);
          rd_en   = 1'b1;
          state_d = (WAIT_STATES == 0) ? StAccess : StWait;
        end
      end
      StWait: begin
        if (!PSEL) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (PENABLE) begin
          if (cnt_q <= 4'd1) begin
            state_d = StAccess;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      StAccess: begin
        // Completion or abort both end the transfer; only a real completion writes.
        wr_en   = xfer & write_q & ~err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and transfer registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  // Reads use the live bus address on the setup edge; writes use the latched index.
  assign ram_addr = (state_q == StIdle) ? PADDR[IdxW+1:2] : idx_q;

  apb_mem_slave_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk  (PCLK),
    .rst  (PRESET),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .addr (ram_addr),
    .wdata(PWDATA),
    .rdata(ram_rdata)
  );

  assign PREADY  = (state_q == StAccess);
  assign PSLVERR = (state_q == StAccess) & err_q;
  assign PRDATA  = err_q ? '0 : ram_rdata;

endmodule
